// File: rtl/riscv_base_divider_pipe.sv
// Multi-cycle restoring integer divider for the RISC-V base core.
// Retires BITS_PER_CYCLE quotient bits per clock. Takes a pre-decoded
// operation, uses valid/ready handshakes on both sides, and supports
// flush and a destination-register tag.
module riscv_base_divider_pipe #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [4:0]      req_rd_idx_i,
  input  logic [XLEN-1:0] req_ra_operand_i,
  input  logic [XLEN-1:0] req_rb_operand_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_idx_o,
  output logic [XLEN-1:0] wb_value_o
);

  localparam int unsigned ITER = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Reject illegal parameterisations at elaboration time.
  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  if (XLEN < 8 || (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_xlen
    $error("XLEN must be >= 8 and a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            neg_in;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN:0]   step_tmp;
  logic [XLEN-1:0] fix_sel;
  logic [XLEN-1:0] fix_val;

  assign req_ready_o = (state_q == IDLE) & ~flush_i;
  assign busy_o      = (state_q != IDLE);

  // Operand magnitudes, result sign and special-case detection at accept.
  always_comb begin
    is_signed = ~req_op_i[0];
    a_neg     = is_signed & req_ra_operand_i[XLEN-1];
    b_neg     = is_signed & req_rb_operand_i[XLEN-1];
    a_abs     = a_neg ? ('0 - req_ra_operand_i) : req_ra_operand_i;
    b_abs     = b_neg ? ('0 - req_rb_operand_i) : req_rb_operand_i;
    neg_in    = req_op_i[1] ? a_neg : (a_neg ^ b_neg);
    div_zero  = (req_rb_operand_i == '0);
    overflow  = is_signed & (req_ra_operand_i == MIN_NEG) &
                (req_rb_operand_i == '1);
  end

  // BITS_PER_CYCLE chained restoring steps on the {rem, quo} pair.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    step_tmp = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      step_tmp = {step_rem, step_quo[XLEN-1]};
      step_quo = {step_quo[XLEN-2:0], 1'b0};
      if (step_tmp >= {1'b0, div_q}) begin
        step_tmp    = step_tmp - {1'b0, div_q};
        step_quo[0] = 1'b1;
      end
      step_rem = step_tmp[XLEN-1:0];
    end
  end

  // Result selection and sign correction.
  always_comb begin
    fix_sel = op_q[1] ? rem_q : quo_q;
    fix_val = neg_q ? ('0 - fix_sel) : fix_sel;
  end

  // Controller with registered writeback outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wb_valid_o  <= 1'b0;
      wb_value_o  <= '0;
      wb_rd_idx_o <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      neg_q       <= 1'b0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      wb_valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op_q        <= req_op_i;
            wb_rd_idx_o <= req_rd_idx_i;
            div_q       <= b_abs;
            quo_q       <= a_abs;
            rem_q       <= '0;
            cnt_q       <= CW'(ITER);
            neg_q       <= neg_in;
            if (div_zero) begin
              wb_value_o <= req_op_i[1] ? req_ra_operand_i : '1;
              wb_valid_o <= 1'b1;
              state_q    <= DONE;
            end else if (overflow) begin
              wb_value_o <= req_op_i[1] ? '0 : req_ra_operand_i;
              wb_valid_o <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          wb_value_o <= fix_val;
          wb_valid_o <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_base_divider_pipe.sv
// Scoreboard bench for riscv_base_divider_pipe: one instance at one bit per
// cycle and one at four bits per cycle, sharing request and control inputs.
module tb_riscv_base_divider_pipe;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wb_ready = 1'b1;
  logic [1:0]  req_op = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        valid1 = 1'b0, valid4 = 1'b0;
  logic        ready1, ready4, busy1, busy4, wbv1, wbv4;
  logic [4:0]  wbrd1, wbrd4;
  logic [31:0] wbval1, wbval4;

  exp_t q1[$];
  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  riscv_base_divider_pipe #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid1), .req_ready_o(ready1),
    .req_op_i(req_op), .req_rd_idx_i(req_rd), .req_ra_operand_i(req_a),
    .req_rb_operand_i(req_b), .flush_i(flush), .busy_o(busy1),
    .wb_valid_o(wbv1), .wb_ready_i(wb_ready), .wb_rd_idx_o(wbrd1), .wb_value_o(wbval1)
  );

  riscv_base_divider_pipe #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid4), .req_ready_o(ready4),
    .req_op_i(req_op), .req_rd_idx_i(req_rd), .req_ra_operand_i(req_a),
    .req_rb_operand_i(req_b), .flush_i(flush), .busy_o(busy4),
    .wb_valid_o(wbv4), .wb_ready_i(wb_ready), .wb_rd_idx_o(wbrd4), .wb_value_o(wbval4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int s);
    return s != 0 ? ready4 : ready1;
  endfunction

  function automatic logic get_wbv(input int s);
    return s != 0 ? wbv4 : wbv1;
  endfunction

  // Reference results with RISC-V semantics, independent of the datapath.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      OP_DIV:  return 32'($signed(a) / $signed(b));
      OP_DIVU: return a / b;
      OP_REM:  return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Scoreboard: compare each accepted writeback, and check ready/valid exclusivity.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      check("excl1", 32'(ready1 & wbv1), 32'h0);
      check("excl4", 32'(ready4 & wbv4), 32'h0);
    end
    if (wbv1 && wb_ready) begin
      if (q1.size() == 0) check("wb1_unexpected", 32'(wbv1), 32'h0);
      else begin
        e = q1.pop_front();
        check("wb1_value", wbval1, e.value);
        check("wb1_rd", 32'(wbrd1), 32'(e.rd));
      end
    end
    if (wbv4 && wb_ready) begin
      if (q4.size() == 0) check("wb4_unexpected", 32'(wbv4), 32'h0);
      else begin
        e = q4.pop_front();
        check("wb4_value", wbval4, e.value);
        check("wb4_rd", 32'(wbrd4), 32'(e.rd));
      end
    end
  end

  // Drive one request into instance s; returns #1 after the accept edge.
  task automatic issue(input int s, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (get_ready(s)) break;
    end
    check("req_ready", 32'(get_ready(s)), 32'h1);
    req_op = op; req_a = a; req_b = b; req_rd = rd;
    if (s != 0) begin valid4 = 1'b1; q4.push_back('{exp, rd}); end
    else        begin valid1 = 1'b1; q1.push_back('{exp, rd}); end
    @(posedge clk); #1;
    valid1 = 1'b0; valid4 = 1'b0;
  endtask

  // Latency counted in cycles: the cycle right after accept is latency 1.
  task automatic wait_valid(input int s, input int exp_lat, input string tag);
    int lat = 1;
    while (!get_wbv(s) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic run(input int s, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input int lat, input string tag);
    issue(s, op, a, b, rd, exp);
    wait_valid(s, lat, tag);
  endtask

  task automatic expect_quiet(input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      seen = seen | wbv1 | wbv4;
    end
    check(tag, 32'(seen), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_wbv", 32'(wbv1), 32'h0);
    check("rst_value", wbval1, 32'h0);
    check("rst_rd", 32'(wbrd1), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(ready1), 32'h1);

    run(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 34, "lat_div_bpc1");
    run(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34, "lat_rem_bpc1");
    run(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 10, "lat_div_bpc4");
    run(1, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 10, "lat_rem_bpc4");
    run(0, OP_DIVU, 32'hFFFF_FFFF, 32'h0, 5'd6, 32'hFFFF_FFFF, 1, "lat_divu_by0");
    run(0, OP_REMU, 32'h0000_1234, 32'h0, 5'd7, 32'h0000_1234, 1, "lat_remu_by0");
    run(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, "lat_div_ovf");
    run(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, 1, "lat_rem_ovf");
    run(1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1, "lat_rem_ovf4");

    // Output backpressure: result and tag held while the consumer stalls.
    wb_ready = 1'b0;
    run(0, OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34, "lat_bp");
    for (int k = 0; k < 6; k++) begin
      check("bp_valid", 32'(wbv1), 32'h1);
      check("bp_value", wbval1, 32'd14);
      check("bp_rd", 32'(wbrd1), 32'd5);
      check("bp_ready", 32'(ready1), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk); wb_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_busy", 32'(busy1), 32'h0);
    check("bp_idle_wbv", 32'(wbv1), 32'h0);
    check("bp_idle_ready", 32'(ready1), 32'h1);

    // Flush in the middle of CALC discards the operation.
    issue(0, OP_DIVU, 32'd5000, 32'd3, 5'd11, 32'd1666);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    check("flush_ready", 32'(ready1), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    void'(q1.pop_back());
    check("flush_busy", 32'(busy1), 32'h0);
    check("flush_wbv", 32'(wbv1), 32'h0);
    expect_quiet("flush_no_wb");
    run(0, OP_REMU, 32'd100, 32'd7, 5'd12, 32'd2, 34, "lat_after_flush");

    // Reset in the middle of CALC discards the operation.
    issue(0, OP_DIVU, 32'd1000, 32'd3, 5'd13, 32'd333);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    void'(q1.pop_back());
    check("mrst_busy", 32'(busy1), 32'h0);
    check("mrst_wbv", 32'(wbv1), 32'h0);
    check("mrst_value", wbval1, 32'h0);
    check("mrst_rd", 32'(wbrd1), 32'h0);
    @(negedge clk); rst = 1'b0;
    expect_quiet("mrst_no_wb");
    run(0, OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFF2, 34, "lat_after_rst");

    // Mixed random operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          sel, lat;
      op  = 2'($urandom_range(0, 3));
      a   = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      lat = (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 10;
      run(1, op, a, b, 5'(i + 16), ref_res(op, a, b), lat, "lat_rand");
    end

    repeat (3) @(posedge clk);
    #1;
    check("q1_drained", 32'(q1.size()), 32'h0);
    check("q4_drained", 32'(q4.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
